// File: rtl/seq_mul_32_if.sv
// Handshake and result bus between the control unit and the iterative multiplier.
interface seq_mul_32_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             is_signed;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] prod_hi;
   logic [WIDTH-1:0] prod_lo;

   modport master (
      output start, a, b, is_signed,
      input  busy, done, prod_hi, prod_lo
   );

   modport slave (
      input  start, a, b, is_signed,
      output busy, done, prod_hi, prod_lo
   );
endinterface

// File: rtl/seq_mul_32.sv
// Iterative shift-add multiplier, one partial-product bit per clock, WIDTH+1 edges to done.
// Optional two's-complement mode is compiled in with the SEQ_MUL_SIGNED_EN macro.
module seq_mul_32 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic         clk,
   input logic         rst_n,
   seq_mul_32_if.slave mulBus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH:0]   r_acc;
   logic [CNT_W-1:0]   r_count;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_prodHi;
   logic [WIDTH-1:0]   r_prodLo;

   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH:0]   w_accNext;
   logic [WIDTH-1:0]   w_aIn;
   logic [WIDTH-1:0]   w_bIn;
   logic [2*WIDTH-1:0] w_product;

   // One iteration: conditionally add the multiplicand into the upper half, keeping the carry, then shift.
   always_comb begin
      w_sum = r_acc[2*WIDTH:WIDTH];
      if (r_acc[0]) begin
         w_sum = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};
      end
      w_accNext = {w_sum, r_acc[WIDTH-1:0]} >> 1;
   end

`ifdef SEQ_MUL_SIGNED_EN
   logic r_negate;
   logic w_negate;

   // Signed operands iterate as magnitudes; the most negative value keeps its bit pattern as an unsigned magnitude.
   always_comb begin
      w_aIn     = (mulBus.is_signed && mulBus.a[WIDTH-1]) ? -mulBus.a : mulBus.a;
      w_bIn     = (mulBus.is_signed && mulBus.b[WIDTH-1]) ? -mulBus.b : mulBus.b;
      w_negate  = mulBus.is_signed && (mulBus.a[WIDTH-1] ^ mulBus.b[WIDTH-1]);
      w_product = r_negate ? -w_accNext[2*WIDTH-1:0] : w_accNext[2*WIDTH-1:0];
   end
`else
   logic w_unusedSigned;

   assign w_unusedSigned = mulBus.is_signed;

   always_comb begin
      w_aIn     = mulBus.a;
      w_bIn     = mulBus.b;
      w_product = w_accNext[2*WIDTH-1:0];
   end
`endif

   // Control and datapath share one register block so busy/done/prod move together with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_prodHi <= '0;
         r_prodLo <= '0;
`ifdef SEQ_MUL_SIGNED_EN
         r_negate <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (mulBus.start) begin
                  r_mcand  <= w_aIn;
                  r_acc    <= {{(WIDTH+1){1'b0}}, w_bIn};
                  r_count  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
`ifdef SEQ_MUL_SIGNED_EN
                  r_negate <= w_negate;
`endif
               end
            end
            RUN: begin
               r_acc   <= w_accNext;
               r_count <= r_count + 1'b1;
               if (r_count == CNT_W'(WIDTH - 1)) begin
                  r_prodHi <= w_product[2*WIDTH-1:WIDTH];
                  r_prodLo <= w_product[WIDTH-1:0];
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign mulBus.busy    = r_busy;
   assign mulBus.done    = r_done;
   assign mulBus.prod_hi = r_prodHi;
   assign mulBus.prod_lo = r_prodLo;

endmodule

// File: tb/tb_seq_mul_32.sv
// Directed self-checking bench for seq_mul_32: vector table plus hand-written latency,
// back-to-back, operand-change and mid-operation reset sequences.
module tb_seq_mul_32;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] expProd;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   seq_mul_32_if #(.WIDTH(32)) mulBus ();

   seq_mul_32 #(.WIDTH(32), .CNT_W(6)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mulBus (mulBus)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison goes through here so the counters stay consistent.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Waits until the multiplier is back in IDLE (neither busy nor done), bounded.
   task automatic waitIdle(input string name);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (!mulBus.busy && !mulBus.done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checkOutput(name, {63'b0, seen}, 64'd1);
   endtask

   // Launches one multiply and returns the product and edges from acceptance to done (-1 on timeout).
   task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                                input logic clearAfter, output logic [63:0] prod, output int lat);
      waitIdle("idle before op");
      mulBus.a         = ia;
      mulBus.b         = ib;
      mulBus.is_signed = is;
      mulBus.start     = 1'b1;
      @(posedge clk);
      #1;
      mulBus.start = 1'b0;
      if (clearAfter) begin
         mulBus.a         = '0;
         mulBus.b         = '0;
         mulBus.is_signed = 1'b0;
      end
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (mulBus.done) begin
            lat = k;
            break;
         end
      end
      prod = {mulBus.prod_hi, mulBus.prod_lo};
   endtask

   initial begin
      vec_t        vecs [10];
      logic [63:0] prod;
      int          lat;
      int          firstDone;
      int          secondDone;
      int          doneCount;
      logic [63:0] firstProd;
      logic [63:0] secondProd;

      total = 0;
      bad   = 0;

      vecs[0] = '{"7x6",          32'd7,          32'd6,          1'b0, 64'd42};
      vecs[1] = '{"allOnes",      32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE_00000001};
      vecs[2] = '{"zeroA",        32'h00000000,   32'h12345678,   1'b0, 64'd0};
      vecs[3] = '{"zeroB",        32'h87654321,   32'h00000000,   1'b0, 64'd0};
      vecs[4] = '{"carryOut",     32'hFFFFFFFF,   32'd2,          1'b0, 64'h00000001_FFFFFFFE};
      vecs[5] = '{"decimal",      32'd123456,     32'd1000,       1'b0, 64'h00000000_075BCA00};
      vecs[6] = '{"unsNeg3x5",    32'hFFFFFFFD,   32'd5,          1'b0, 64'h00000004_FFFFFFF1};
      vecs[7] = '{"minxminS",     32'h80000000,   32'h80000000,   1'b1, 64'h40000000_00000000};
`ifdef SEQ_MUL_SIGNED_EN
      vecs[8] = '{"sNeg3x5",      32'hFFFFFFFD,   32'd5,          1'b1, 64'hFFFFFFFF_FFFFFFF1};
      vecs[9] = '{"sNeg1xNeg1",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'h00000000_00000001};
`else
      vecs[8] = '{"sIgnNeg3x5",   32'hFFFFFFFD,   32'd5,          1'b1, 64'h00000004_FFFFFFF1};
      vecs[9] = '{"sIgnNeg1",     32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'hFFFFFFFE_00000001};
`endif

      mulBus.start     = 1'b0;
      mulBus.a         = '0;
      mulBus.b         = '0;
      mulBus.is_signed = 1'b0;

      // Reset held for three cycles, then quiet idle with no start.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("reset busy", {63'b0, mulBus.busy}, 64'd0);
      checkOutput("reset done", {63'b0, mulBus.done}, 64'd0);
      checkOutput("reset prod", {mulBus.prod_hi, mulBus.prod_lo}, 64'd0);
      doneCount = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (mulBus.busy || mulBus.done) doneCount++;
      end
      checkOutput("idle activity", 64'(doneCount), 64'd0);

      // Cycle-exact latency trace for 7 x 6 with a single-cycle start pulse.
      mulBus.a     = 32'd7;
      mulBus.b     = 32'd6;
      mulBus.start = 1'b1;
      @(posedge clk);
      #1;
      mulBus.start = 1'b0;
      checkOutput("lat busy e0", {63'b0, mulBus.busy}, 64'd1);
      for (int k = 1; k <= 33; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("lat busy e%0d", k), {63'b0, mulBus.busy}, (k < 32) ? 64'd1 : 64'd0);
         checkOutput($sformatf("lat done e%0d", k), {63'b0, mulBus.done}, (k == 32) ? 64'd1 : 64'd0);
         if (k >= 32) checkOutput($sformatf("lat prod e%0d", k), {mulBus.prod_hi, mulBus.prod_lo}, 64'd42);
      end

      // Table of single operations.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, prod, lat);
         checkOutput({vecs[i].name, " prod"}, prod, vecs[i].expProd);
         checkOutput({vecs[i].name, " latency"}, 64'(lat), 64'd32);
      end

      // Start held high: back-to-back operations 34 cycles apart, start ignored while running.
      waitIdle("idle before b2b");
      mulBus.a         = 32'hFFFFFFFF;
      mulBus.b         = 32'hFFFFFFFF;
      mulBus.is_signed = 1'b0;
      mulBus.start     = 1'b1;
      firstDone  = -1;
      secondDone = -1;
      firstProd  = '0;
      secondProd = '0;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk);
         #1;
         if (mulBus.done) begin
            if (firstDone < 0) begin
               firstDone = k;
               firstProd = {mulBus.prod_hi, mulBus.prod_lo};
            end else if (secondDone < 0) begin
               secondDone = k;
               secondProd = {mulBus.prod_hi, mulBus.prod_lo};
            end
         end
      end
      mulBus.start = 1'b0;
      checkOutput("b2b first done", 64'(firstDone), 64'd33);
      checkOutput("b2b period", 64'(secondDone - firstDone), 64'd34);
      checkOutput("b2b first prod", firstProd, 64'hFFFFFFFE_00000001);
      checkOutput("b2b second prod", secondProd, 64'hFFFFFFFE_00000001);

      // Operands cleared right after acceptance must not affect the result.
      applyStimulus(32'h00010000, 32'h00010000, 1'b0, 1'b1, prod, lat);
      checkOutput("opchange prod", prod, 64'h00000001_00000000);
      checkOutput("opchange latency", 64'(lat), 64'd32);

      // Reset ten cycles into RUN: outputs clear at once and no done follows.
      waitIdle("idle before reset op");
      mulBus.a     = 32'd3;
      mulBus.b     = 32'd5;
      mulBus.start = 1'b1;
      @(posedge clk);
      #1;
      mulBus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset busy", {63'b0, mulBus.busy}, 64'd0);
      checkOutput("midreset done", {63'b0, mulBus.done}, 64'd0);
      checkOutput("midreset prod", {mulBus.prod_hi, mulBus.prod_lo}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      doneCount = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (mulBus.done || mulBus.busy) doneCount++;
      end
      checkOutput("midreset no done", 64'(doneCount), 64'd0);
      applyStimulus(32'd2, 32'd9, 1'b0, 1'b0, prod, lat);
      checkOutput("postreset prod", prod, 64'd18);
      checkOutput("postreset latency", 64'(lat), 64'd32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
